// File: rtl/nasser_hadi_input_conditioner.sv
// nasser_hadi_input_conditioner: synchronise and debounce raw a/b/c pins, with stable/changed status.
// Define INPUT_COND_EDGE_EN to add per-channel rise/fall pulse outputs.
module nasser_hadi_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       stable,
  output logic       changed
`ifdef INPUT_COND_EDGE_EN
  ,
  output logic [2:0] rise,
  output logic [2:0] fall
`endif
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;
  logic [2:0] raw, s, x, x_n, st, st_n;
  logic [2:0][SYNC_STAGES-1:0] sh;
  logic [2:0][CNT_W-1:0] cnt, cnt_n;
  logic stable_n;
  assign raw = {raw_c, raw_b, raw_a};
  assign {c, b, a} = x;
  genvar i;
  for (i = 0; i < 3; i++) begin : g_s
    assign s[i] = sh[i][SYNC_STAGES-1];
  end
  // Only ena=1 edges advance a channel; a match during SETTLE discards the partial count.
  always_comb begin
    x_n = x;
    st_n = st;
    cnt_n = cnt;
    for (int j = 0; j < 3; j++)
      if (ena && st[j] == SETTLE) begin
        if (s[j] == x[j]) begin
          st_n[j] = IDLE;
          cnt_n[j] = '0;
        end else if (cnt[j] == CNT_W'(DB_CYCLES - 1)) begin
          x_n[j] = s[j];
          st_n[j] = IDLE;
          cnt_n[j] = '0;
        end else
          cnt_n[j] = cnt[j] + CNT_W'(1);
      end else if (ena && s[j] != x[j]) begin
        if (DB_CYCLES == 1)
          x_n[j] = s[j];
        else begin
          st_n[j] = SETTLE;
          cnt_n[j] = CNT_W'(1);
        end
      end
    stable_n = ena && st_n == {3{IDLE}} && s == x_n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
      st <= {3{IDLE}};
      x <= '0;
      stable <= 1'b0;
      changed <= 1'b0;
`ifdef INPUT_COND_EDGE_EN
      rise <= '0;
      fall <= '0;
`endif
    end else begin
      for (int j = 0; j < 3; j++)
        sh[j] <= {sh[j][SYNC_STAGES-2:0], raw[j]};
      x <= x_n;
      st <= st_n;
      cnt <= cnt_n;
      stable <= stable_n;
      changed <= |(x_n ^ x);
`ifdef INPUT_COND_EDGE_EN
      rise <= x_n & ~x;
      fall <= ~x_n & x;
`endif
    end
endmodule
